// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared types and defaults for the two-port SDRAM arbiter
package sdram_pkg;

    localparam int SDRAM_ADDR_DEPTH = 25;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } sdram_state_t;

    // Identifies which requester owns a command or an outstanding read.
    typedef logic port_tag_t;

endpackage

// File: rtl/sdram_tag_fifo.sv
// rtl/sdram_tag_fifo.sv - in-order queue of port tags for reads awaiting return data
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, tag_in    enqueue the owning port of a newly accepted read
//   pop, tag_out    dequeue on read return; tag_out is the oldest entry
//   count           number of reads in flight
//   full, empty     occupancy flags
module sdram_tag_fifo
    import sdram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     tag_in,
    output logic                     tag_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign tag_out = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a push into a full queue
    // is accepted when it coincides with a pop.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = tag_in;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sdram_arbiter_2p.sv
// rtl/sdram_arbiter_2p.sv - round-robin two-port arbiter in front of a byte SDRAM controller
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   p<i>_req/we/addr/wdata           port command, held until p<i>_ack
//   p<i>_ack                         command accepted by the controller
//   p<i>_rvalid, p<i>_rdata          read return routed to the owning port
//   sd_wr, sd_rd, sd_addr, sd_wdata  command to the controller, held until sd_rdy
//   sd_rdy, sd_val, sd_rdata         controller accept and read return
//   err_orphan                       sticky: read data arrived with none outstanding
module sdram_arbiter_2p
    import sdram_pkg::*;
#(
    parameter int TAG_DEPTH  = 4,
    parameter int ADDR_DEPTH = SDRAM_ADDR_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_DEPTH-1:0] p0_addr,
    input  logic [7:0]            p0_wdata,
    output logic                  p0_ack,
    output logic                  p0_rvalid,
    output logic [7:0]            p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_DEPTH-1:0] p1_addr,
    input  logic [7:0]            p1_wdata,
    output logic                  p1_ack,
    output logic                  p1_rvalid,
    output logic [7:0]            p1_rdata,
    output logic                  sd_wr,
    output logic                  sd_rd,
    output logic [ADDR_DEPTH-1:0] sd_addr,
    output logic [7:0]            sd_wdata,
    input  logic                  sd_rdy,
    input  logic                  sd_val,
    input  logic [7:0]            sd_rdata,
    output logic                  err_orphan
);

    localparam int CW = $clog2(TAG_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_DEPTH = CW'(TAG_DEPTH);

    sdram_state_t          state_q, state_d;
    port_tag_t             grant_q, grant_d;
    port_tag_t             last_grant_q, last_grant_d;
    logic                  we_q, we_d;
    logic [ADDR_DEPTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  err_orphan_q, err_orphan_d;

    logic          fifo_push;
    logic          fifo_pop;
    port_tag_t     fifo_tag_out;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    logic      issuing;
    logic      accept;
    logic      rd_room;
    logic      elig0;
    logic      elig1;
    port_tag_t pick;

    sdram_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .tag_in  (grant_q),
        .tag_out (fifo_tag_out),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign issuing = (state_q == ST_ISSUE);
    assign accept  = issuing && sd_rdy;
    assign rd_room = (fifo_count < CNT_DEPTH);
    assign elig0   = p0_req && (p0_we || rd_room);
    assign elig1   = p1_req && (p1_we || rd_room);

    // Reads are only granted with room in the queue, so the full guard never
    // drops a tag; it keeps the queue consistent if that ever changes.
    assign fifo_push = accept && !we_q && !fifo_full;
    assign fifo_pop  = sd_val && !fifo_empty;

    assign sd_rd      = issuing && !we_q;
    assign sd_wr      = issuing && we_q;
    assign sd_addr    = addr_q;
    assign sd_wdata   = wdata_q;
    assign p0_ack     = accept && (grant_q == 1'b0);
    assign p1_ack     = accept && (grant_q == 1'b1);
    assign p0_rvalid  = fifo_pop && (fifo_tag_out == 1'b0);
    assign p1_rvalid  = fifo_pop && (fifo_tag_out == 1'b1);
    assign p0_rdata   = sd_rdata;
    assign p1_rdata   = sd_rdata;
    assign err_orphan = err_orphan_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_orphan_d = err_orphan_q | (sd_val && fifo_empty);

        // With both eligible the port not served last wins; otherwise the
        // single eligible port wins.
        if (elig0 && elig1) begin
            pick = ~last_grant_q;
        end else begin
            pick = elig1;
        end

        case (state_q)
            ST_IDLE: begin
                if (elig0 || elig1) begin
                    state_d = ST_ISSUE;
                    grant_d = pick;
                    we_d    = pick ? p1_we    : p0_we;
                    addr_d  = pick ? p1_addr  : p0_addr;
                    wdata_d = pick ? p1_wdata : p0_wdata;
                end
            end
            ST_ISSUE: begin
                if (sd_rdy) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_orphan_q <= err_orphan_d;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter_2p.sv
// tb/tb_sdram_arbiter_2p.sv - self-checking bench for sdram_arbiter_2p
module tb_sdram_arbiter_2p;

    localparam int TD = 4;
    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [7:0]    p0_wdata, p1_wdata;
    logic          p0_ack, p1_ack, p0_rvalid, p1_rvalid;
    logic [7:0]    p0_rdata, p1_rdata;
    logic          sd_wr, sd_rd, sd_rdy, sd_val, err_orphan;
    logic [AW-1:0] sd_addr;
    logic [7:0]    sd_wdata, sd_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    sdram_arbiter_2p #(.TAG_DEPTH(TD), .ADDR_DEPTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .sd_wr(sd_wr), .sd_rd(sd_rd), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
        .sd_rdy(sd_rdy), .sd_val(sd_val), .sd_rdata(sd_rdata),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one pending command slot and a queue of read owners.
    bit            m_busy = 0;
    int            m_port = 0;
    bit            m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [7:0]    m_wdata = '0;
    int            m_last = 1;
    bit            m_orph = 0;
    int            tagq[$];
    int            m_n, m_win;
    bit            m_e0, m_e1, x_rv0, x_rv1;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("m_rst_sd_rd", 32'(sd_rd), 0);
            chk("m_rst_sd_wr", 32'(sd_wr), 0);
            chk("m_rst_ack", 32'({p0_ack, p1_ack}), 0);
            chk("m_rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 0);
            chk("m_rst_orphan", 32'(err_orphan), 0);
            chk("m_rst_addr", 32'(sd_addr), 0);
            chk("m_rst_wdata", 32'(sd_wdata), 0);
            m_busy = 0; m_last = 1; m_orph = 0; m_addr = '0; m_wdata = '0;
            tagq.delete();
        end else begin
            x_rv0 = sd_val && tagq.size() > 0 && tagq[0] == 0;
            x_rv1 = sd_val && tagq.size() > 0 && tagq[0] == 1;
            chk("m_sd_rd", 32'(sd_rd), 32'(m_busy && !m_we));
            chk("m_sd_wr", 32'(sd_wr), 32'(m_busy && m_we));
            chk("m_sd_addr", 32'(sd_addr), 32'(m_addr));
            chk("m_sd_wdata", 32'(sd_wdata), 32'(m_wdata));
            chk("m_p0_ack", 32'(p0_ack), 32'(m_busy && sd_rdy && m_port == 0));
            chk("m_p1_ack", 32'(p1_ack), 32'(m_busy && sd_rdy && m_port == 1));
            chk("m_p0_rvalid", 32'(p0_rvalid), 32'(x_rv0));
            chk("m_p1_rvalid", 32'(p1_rvalid), 32'(x_rv1));
            chk("m_rdata", 32'({p0_rdata, p1_rdata}), 32'({sd_rdata, sd_rdata}));
            chk("m_orphan", 32'(err_orphan), 32'(m_orph));
            m_n = tagq.size();
            if (sd_val) begin
                if (m_n > 0) void'(tagq.pop_front());
                else m_orph = 1;
            end
            if (m_busy) begin
                if (sd_rdy) begin
                    if (!m_we) tagq.push_back(m_port);
                    m_last = m_port;
                    m_busy = 0;
                end
            end else begin
                m_e0 = p0_req && (p0_we || m_n < TD);
                m_e1 = p1_req && (p1_we || m_n < TD);
                if (m_e0 || m_e1) begin
                    m_win  = (m_e0 && m_e1) ? 1 - m_last : (m_e0 ? 0 : 1);
                    m_busy = 1;
                    m_port = m_win;
                    m_we   = m_win ? p1_we : p0_we;
                    m_addr = m_win ? p1_addr : p0_addr;
                    m_wdata = m_win ? p1_wdata : p0_wdata;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [7:0] d);
        if (p == 0) begin
            p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic do_cmd(input int p, input logic w, input logic [AW-1:0] a, input logic [7:0] d);
        bit got;
        got = 0;
        set_port(p, 1'b1, w, a, d);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if ((p == 0) ? p0_ack : p1_ack) got = 1;
            tick();
        end
        set_port(p, 1'b0, w, a, d);
        chk("cmd_ack_timeout", 32'(got), 1);
    endtask

    task automatic drain(input int o0, input int o1, input int o2, input int o3);
        int ord[4];
        ord = '{o0, o1, o2, o3};
        for (int k = 0; k < 4; k++) begin
            sd_val   = 1'b1;
            sd_rdata = 8'(8'h30 + k);
            @(negedge clk);
            chk("drain_p0_rvalid", 32'(p0_rvalid), 32'(ord[k] == 0));
            chk("drain_p1_rvalid", 32'(p1_rvalid), 32'(ord[k] == 1));
            chk("drain_rdata", 32'(ord[k] == 0 ? p0_rdata : p1_rdata), 32'(8'h30 + k));
            tick();
        end
        sd_val = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cnt, a1_cnt, a0_cnt;
        bit a0, a1;
        rst_n = 1'b0; sd_rdy = 1'b1; sd_val = 1'b0; sd_rdata = '0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("rst_sd_rd", 32'(sd_rd), 0);
        chk("rst_sd_addr", 32'(sd_addr), 0);
        chk("rst_err_orphan", 32'(err_orphan), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single read.
        set_port(0, 1'b1, 1'b0, 25'h0000123, 8'h00);
        @(negedge clk);
        chk("rd_cycle0_sd_rd", 32'(sd_rd), 0);
        tick();
        @(negedge clk);
        chk("rd_sd_rd", 32'(sd_rd), 1);
        chk("rd_p0_ack", 32'(p0_ack), 1);
        chk("rd_sd_addr", 32'(sd_addr), 32'h123);
        tick();
        p0_req = 1'b0;
        tick();
        sd_val = 1'b1; sd_rdata = 8'h5A;
        @(negedge clk);
        chk("rd_p0_rvalid", 32'(p0_rvalid), 1);
        chk("rd_p0_rdata", 32'(p0_rdata), 32'h5A);
        chk("rd_p1_rvalid", 32'(p1_rvalid), 0);
        tick();
        sd_val = 1'b0;

        // Contention from reset: grants alternate p0, p1 with acks 2 cycles apart.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        set_port(0, 1'b1, 1'b1, 25'h0000AAA, 8'h11);
        set_port(1, 1'b1, 1'b1, 25'h0000BBB, 8'h22);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("cont_p0_ack", 32'(p0_ack), 32'(k % 4 == 1));
            chk("cont_p1_ack", 32'(p1_ack), 32'(k % 4 == 3));
            chk("cont_sd_wr", 32'(sd_wr), 32'(k % 2 == 1));
            tick();
        end
        p0_req = 1'b0; p1_req = 1'b0;
        tick();

        // Backpressure: command held stable, port inputs changed after grant.
        sd_rdy = 1'b0;
        set_port(1, 1'b1, 1'b1, 25'h1ABCDEF, 8'hC3);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 2) begin p1_addr = 25'h0000042; p1_wdata = 8'h99; p1_we = 1'b0; end
            @(negedge clk);
            chk("bp_sd_wr", 32'(sd_wr), 1);
            chk("bp_sd_addr", 32'(sd_addr), 32'h1ABCDEF);
            chk("bp_no_ack", 32'(p1_ack), 0);
        end
        tick();
        sd_rdy = 1'b1;
        @(negedge clk);
        chk("bp_ack", 32'(p1_ack), 1);
        chk("bp_sd_wdata", 32'(sd_wdata), 32'hC3);
        tick();
        p1_req = 1'b0;

        // Four reads fill the tag queue; a fifth read waits, a write still goes.
        do_cmd(0, 1'b0, 25'h10, 8'h0);
        do_cmd(1, 1'b0, 25'h11, 8'h0);
        do_cmd(1, 1'b0, 25'h12, 8'h0);
        do_cmd(0, 1'b0, 25'h13, 8'h0);
        set_port(0, 1'b1, 1'b0, 25'h14, 8'h0);
        set_port(1, 1'b1, 1'b1, 25'h15, 8'h5);
        rd_cnt = 0; a1_cnt = 0; a0_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rd_cnt += int'(sd_rd); a1_cnt += int'(p1_ack); a0_cnt += int'(p0_ack);
            a1 = p1_ack;
            tick();
            if (a1) p1_req = 1'b0;
        end
        chk("full_no_rd", 32'(rd_cnt), 0);
        chk("full_wr_acks", 32'(a1_cnt), 1);
        chk("full_no_p0_ack", 32'(a0_cnt), 0);
        p0_req = 1'b0;
        drain(0, 1, 1, 0);

        // Push and pop together keep the count: three queued, then read with return.
        do_cmd(0, 1'b0, 25'h20, 8'h0);
        do_cmd(1, 1'b0, 25'h21, 8'h0);
        do_cmd(0, 1'b0, 25'h22, 8'h0);
        sd_rdy = 1'b0;
        set_port(1, 1'b1, 1'b0, 25'h23, 8'h0);
        tick();
        @(negedge clk);
        chk("pp_sd_rd", 32'(sd_rd), 1);
        tick();
        sd_rdy = 1'b1; sd_val = 1'b1; sd_rdata = 8'h77;
        @(negedge clk);
        chk("pp_p1_ack", 32'(p1_ack), 1);
        chk("pp_p0_rvalid", 32'(p0_rvalid), 1);
        chk("pp_p0_rdata", 32'(p0_rdata), 32'h77);
        tick();
        p1_req = 1'b0; sd_val = 1'b0;
        do_cmd(0, 1'b0, 25'h24, 8'h0);
        set_port(1, 1'b1, 1'b0, 25'h25, 8'h0);
        rd_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rd_cnt += int'(sd_rd);
            tick();
        end
        chk("pp_full_no_rd", 32'(rd_cnt), 0);
        p1_req = 1'b0;
        drain(1, 0, 1, 0);

        // Orphan return.
        sd_val = 1'b1;
        @(negedge clk);
        chk("orph_no_rvalid", 32'({p0_rvalid, p1_rvalid}), 0);
        chk("orph_not_yet", 32'(err_orphan), 0);
        tick();
        sd_val = 1'b0;
        @(negedge clk);
        chk("orph_set", 32'(err_orphan), 1);
        tick();

        // Reset while a read is waiting in ISSUE.
        sd_rdy = 1'b0;
        set_port(0, 1'b1, 1'b0, 25'h30, 8'h0);
        tick();
        @(negedge clk);
        chk("rst_mid_sd_rd_before", 32'(sd_rd), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_sd_rd", 32'(sd_rd), 0);
        chk("rst_mid_ack", 32'(p0_ack), 0);
        chk("rst_mid_orphan", 32'(err_orphan), 0);
        tick();
        p0_req = 1'b0;
        tick();
        rst_n = 1'b1; sd_rdy = 1'b1;

        // Randomized traffic against the model.
        a0 = 0; a1 = 0;
        for (int c = 0; c < 900; c++) begin
            tick();
            rst_n    = (c % 300 == 299) ? 1'b0 : 1'b1;
            sd_rdy   = ($urandom_range(0, 3) != 0);
            sd_val   = ($urandom_range(0, 3) == 0);
            sd_rdata = 8'($urandom);
            if (!p0_req || a0) begin
                set_port(0, $urandom_range(0, 2) != 0, 1'($urandom), AW'($urandom), 8'($urandom));
            end else if ($urandom_range(0, 7) == 0) begin
                p0_addr = AW'($urandom); p0_wdata = 8'($urandom);
            end
            if (!p1_req || a1) begin
                set_port(1, $urandom_range(0, 2) != 0, 1'($urandom), AW'($urandom), 8'($urandom));
            end else if ($urandom_range(0, 7) == 0) begin
                p1_addr = AW'($urandom); p1_wdata = 8'($urandom);
            end
            @(negedge clk);
            a0 = p0_ack; a1 = p1_ack;
        end
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
